toggle_decoder: RTL and testbench

Receive-side decoder for toggle-encoded event signalling: a source (a T flip-flop style toggle encoder) flips a single level line once per event. This block sits on the receiving end. It synchronises that level, recovers a one-cycle event pulse per transition and measures the clock-cycle interval between events. Intervals are buffered in a small FIFO and read out through a valid/ready handshake.

---
 rtl/toggle_decoder.sv | 109 ++++++++++
 tb/tb_toggle_decoder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_decoder.sv
// toggle_decoder: receive-side decoder for toggle-encoded events with interval FIFO
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   q_in         toggle-encoded level, asynchronous to clk
//   t_pulse      one-cycle pulse per accepted transition
//   q_level      accepted line level
//   ivl_data     FIFO head interval (0 when empty), ivl_valid / ivl_ready handshake
//   fifo_level   number of stored intervals
//   overflow     sticky drop flag, cleared by clr_ovf (a same-cycle drop wins)
// Optional feature: define TOGGLE_DECODER_GLITCH_FILTER_EN to require the
// synchronised level to stay changed for FILT_LEN cycles before acceptance.
module toggle_decoder #(
   parameter int CNT_W      = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int FILT_LEN   = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          q_in,
   output logic                          t_pulse,
   output logic                          q_level,
   output logic [CNT_W-1:0]              ivl_data,
   output logic                          ivl_valid,
   input  logic                          ivl_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   input  logic                          clr_ovf
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   logic             s1_q, s2_q;
   logic             level_q, level_d;
   logic             pulse_q, pulse_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    lvl_q, lvl_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] mem_q [FIFO_DEPTH];
   logic             differ, edge_hit, full, pop, push, drop;

   assign differ = s2_q != level_q;

`ifdef TOGGLE_DECODER_GLITCH_FILTER_EN
   localparam int FW = $clog2(FILT_LEN + 1);
   logic [FW-1:0] stab_q, stab_d;
   // Accept only once the new level has persisted for FILT_LEN cycles.
   assign edge_hit = differ && (stab_q == FW'(FILT_LEN - 1));
   assign stab_d   = differ ? stab_q + 1'b1 : '0;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stab_q <= '0;
      else        stab_q <= stab_d;
   end
`else
   assign edge_hit = differ;
`endif

   assign full = lvl_q == LW'(FIFO_DEPTH);
   assign pop  = ivl_valid && ivl_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push = edge_hit && (!full || pop);
   assign drop = edge_hit && full && !pop;

   always_comb begin
      level_d  = edge_hit ? s2_q : level_q;
      pulse_d  = edge_hit;
      cnt_d    = edge_hit ? CNT_W'(1) : (&cnt_q ? cnt_q : cnt_q + 1'b1);
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      lvl_d    = lvl_q + LW'(push) - LW'(pop);
      ovf_d    = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         level_q  <= 1'b0;
         pulse_q  <= 1'b0;
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         lvl_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         s1_q     <= q_in;
         s2_q     <= s1_q;
         level_q  <= level_d;
         pulse_q  <= pulse_d;
         cnt_q    <= cnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         lvl_q    <= lvl_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage needs no reset: reads are masked by the occupancy count.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= cnt_q;
   end

   assign t_pulse    = pulse_q;
   assign q_level    = level_q;
   assign ivl_valid  = lvl_q != '0;
   assign ivl_data   = ivl_valid ? mem_q[rd_ptr_q] : '0;
   assign fifo_level = lvl_q;
   assign overflow   = ovf_q;
endmodule

// File: tb/tb_toggle_decoder.sv
// tb_toggle_decoder: randomized and directed checks of toggle_decoder against a behavioural model
module tb_toggle_decoder;
   localparam int CNT_W = 8;
   localparam int DEPTH = 4;
   localparam int FILT_LEN = 2;
   localparam int MAXV = (1 << CNT_W) - 1;
`ifdef TOGGLE_DECODER_GLITCH_FILTER_EN
   localparam bit FILT = 1'b1;
   localparam int LAT = FILT_LEN - 1;
`else
   localparam bit FILT = 1'b0;
   localparam int LAT = 0;
`endif

   logic clk = 1'b0;
   logic rst_n, q_in, ivl_ready, clr_ovf;
   logic t_pulse, q_level, ivl_valid, overflow;
   logic [CNT_W-1:0] ivl_data;
   logic [$clog2(DEPTH):0] fifo_level;

   toggle_decoder #(.CNT_W(CNT_W), .FIFO_DEPTH(DEPTH), .FILT_LEN(FILT_LEN)) dut (
      .clk(clk), .rst_n(rst_n), .q_in(q_in), .t_pulse(t_pulse), .q_level(q_level),
      .ivl_data(ivl_data), .ivl_valid(ivl_valid), .ivl_ready(ivl_ready),
      .fifo_level(fifo_level), .overflow(overflow), .clr_ovf(clr_ovf)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int pulses[$];
   int popped[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: two-stage sampled level, accepted level, interval
   // counter with saturation, and the FIFO as a plain queue.
   int m_s1, m_s2, m_level, m_pulse, m_cnt, m_run;
   bit m_ovf, m_diff, m_hit, m_drop;
   int fifo[$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_s1 = 0; m_s2 = 0; m_level = 0; m_pulse = 0; m_cnt = 0; m_run = 0; m_ovf = 0;
         fifo.delete();
      end else begin
         m_diff = m_s2 != m_level;
         m_hit  = m_diff && (!FILT || m_run == FILT_LEN - 1);
         if (fifo.size() > 0 && ivl_ready) void'(fifo.pop_front());
         m_drop = m_hit && fifo.size() >= DEPTH;
         if (m_hit && !m_drop) fifo.push_back(m_cnt);
         m_ovf   = m_drop ? 1'b1 : (clr_ovf ? 1'b0 : m_ovf);
         m_pulse = m_hit ? 1 : 0;
         if (m_hit) m_level = m_s2;
         m_cnt = m_hit ? 1 : (m_cnt < MAXV ? m_cnt + 1 : MAXV);
         m_run = m_diff ? m_run + 1 : 0;
         m_s2  = m_s1;
         m_s1  = q_in;
      end
   end

   // Compare every cycle just before the next rising edge; also log pulses and pops.
   always @(negedge clk) begin
      #4;
      cyc++;
      chk("t_pulse", t_pulse, m_pulse);
      chk("q_level", q_level, m_level);
      chk("ivl_valid", ivl_valid, fifo.size() > 0);
      chk("ivl_data", ivl_data, fifo.size() > 0 ? fifo[0] : 0);
      chk("fifo_level", fifo_level, fifo.size());
      chk("overflow", overflow, m_ovf);
      if (t_pulse) pulses.push_back(cyc);
      if (ivl_valid && ivl_ready) popped.push_back(int'(ivl_data));
   end

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_t_pulse"}, t_pulse, 0);
      chk({tag, "_q_level"}, q_level, 0);
      chk({tag, "_ivl_valid"}, ivl_valid, 0);
      chk({tag, "_overflow"}, overflow, 0);
      chk({tag, "_fifo_level"}, fifo_level, 0);
      chk({tag, "_ivl_data"}, ivl_data, 0);
   endtask

   int rdy_pct;

   initial begin
      rst_n = 1'b0; q_in = 1'b0; ivl_ready = 1'b0; clr_ovf = 1'b0;
      wait_n(3);
      rst_n = 1'b1;
      wait_n(10);
      chk_all_zero("idle");

      // Two transitions five cycles apart, consumer always ready.
      ivl_ready = 1'b1; pulses.delete(); popped.delete();
      q_in = 1'b1;
      wait_n(5);
      q_in = 1'b0;
      wait_n(10);
      chk("two_pulses", pulses.size(), 2);
      if (pulses.size() == 2) chk("pulse_gap", pulses[1] - pulses[0], 5);
      chk("two_pops", popped.size(), 2);
      if (popped.size() == 2) begin
         chk("first_ivl", popped[0], 12 + LAT);
         chk("second_ivl", popped[1], 5);
      end
      chk("level_back_0", q_level, 0);

      // Overflow with a stalled consumer after a fresh reset.
      rst_n = 1'b0;
      wait_n(1);
      rst_n = 1'b1; ivl_ready = 1'b0; popped.delete();
      wait_n(6);
      for (int i = 0; i < 5; i++) begin
         q_in = ~q_in;
         wait_n(4);
      end
      wait_n(2);
      chk("full_level", fifo_level, 4);
      chk("ovf_set", overflow, 1);
      ivl_ready = 1'b1;
      wait_n(6);
      ivl_ready = 1'b0;
      chk("drain_count", popped.size(), 4);
      if (popped.size() == 4) begin
         chk("drain_0", popped[0], 8 + LAT);
         chk("drain_1", popped[1], 4);
         chk("drain_2", popped[2], 4);
         chk("drain_3", popped[3], 4);
      end
      chk("ovf_sticky", overflow, 1);
      clr_ovf = 1'b1;
      wait_n(1);
      clr_ovf = 1'b0;
      chk("ovf_cleared", overflow, 0);

      // Full FIFO, push coinciding with a pop.
      for (int i = 0; i < 4; i++) begin
         q_in = ~q_in;
         wait_n(3);
      end
      wait_n(2);
      chk("refill_level", fifo_level, 4);
      q_in = ~q_in;
      wait_n(2 + LAT);
      ivl_ready = 1'b1;
      wait_n(1);
      ivl_ready = 1'b0;
      chk("pushpop_level", fifo_level, 4);
      chk("pushpop_no_ovf", overflow, 0);
      popped.delete();
      ivl_ready = 1'b1;
      wait_n(6);
      chk("pushpop_drain", popped.size(), 4);
      if (popped.size() == 4) chk("pushpop_tail", popped[3], 5);

      // Saturation, then a one-cycle excursion.
      q_in = ~q_in;
      wait_n(300);
      popped.delete();
      q_in = ~q_in;
      wait_n(8);
      chk("sat_count", popped.size(), 1);
      if (popped.size() == 1) chk("sat_value", popped[0], MAXV);
      popped.delete(); pulses.delete();
      q_in = ~q_in;
      wait_n(1);
      q_in = ~q_in;
      wait_n(8);
      if (FILT) begin
         chk("glitch_pulses", pulses.size(), 0);
         chk("glitch_pops", popped.size(), 0);
      end else begin
         chk("b2b_pulses", pulses.size(), 2);
         if (pulses.size() == 2) chk("b2b_gap", pulses[1] - pulses[0], 1);
         chk("b2b_pops", popped.size(), 2);
         if (popped.size() == 2) chk("b2b_ivl", popped[1], 1);
      end

      // Asynchronous reset with entries stored, release with q_in high.
      ivl_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         q_in = ~q_in;
         wait_n(3);
      end
      wait_n(5);
      chk("pre_reset_level", fifo_level, 3);
      #1 rst_n = 1'b0;
      #1 chk_all_zero("async_rst");
      q_in = 1'b1;
      wait_n(1);
      rst_n = 1'b1;
      wait_n(2 + LAT);
      chk("rel_no_pulse_yet", t_pulse, 0);
      wait_n(1);
      chk("rel_pulse", t_pulse, 1);

      // Randomized traffic.
      rdy_pct = 50;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (i % 500 == 0) rdy_pct = (i / 500) % 3 == 0 ? 10 : ((i / 500) % 3 == 1 ? 50 : 90);
         rst_n = ($urandom_range(0, 1499) != 0);
         if ($urandom_range(0, 3) == 0) q_in = ~q_in;
         ivl_ready = $urandom_range(0, 99) < rdy_pct;
         clr_ovf = $urandom_range(0, 49) == 0;
      end
      rst_n = 1'b1;
      wait_n(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
